eth_frame_wrapper: RTL
======================

ETH_FRAME_WRAPPER -- requirements
Module: eth_frame_wrapper

Interface
REQ-001 Parameter MIN_LEN, default 60: minimum bytes (payload + pad) before FCS; 0 disables padding.
REQ-002 Parameter MAX_LEN, default 1500: maximum payload bytes accepted per frame.
REQ-003 Parameter IFG_SLOTS, default 12: idle byte slots enforced after each FCS.
REQ-004 clk125MHz  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 advance  in  1  byte-slot strobe (speed pacing); state, counters and outputs hold when low.
REQ-007 in_data  in  8  payload byte from the upstream byte generator.
REQ-008 in_valid  in  1  in_data holds a payload byte; contiguous high run = one frame.
REQ-009 in_ready  out  1  high only in PAYLOAD while byte count < MAX_LEN.
REQ-010 out_data  out  8  framed byte to the RGMII transmitter.
REQ-011 out_valid  out  1  out_data valid this slot.
REQ-012 out_enable  out  1  high from first preamble byte through last FCS byte.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 frame_err  out  1  one-cycle pulse on oversize truncation.
REQ-015 frame_count  out  16  frames completed, wraps 0xFFFF->0x0000.

Function
REQ-016 A byte transfers only on a cycle with advance & in_valid & in_ready; in_data is not consumed otherwise.
REQ-017 States: IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, IFG; transitions occur only on advance cycles.
REQ-018 IDLE -> PREAMBLE when advance & in_valid; in_ready stays low, so the first byte is held by the source.
REQ-019 PREAMBLE emits 0x55 for 7 slots, then SFD emits 0xD5 for 1 slot, then PAYLOAD.
REQ-020 PAYLOAD emits each transferred byte; on an advance slot with in_valid low, go to PAD if count < MIN_LEN, else FCS.
REQ-021 In PAYLOAD, a slot with in_valid low emits nothing: out_valid is low and out_enable stays high.
REQ-022 When count reaches MAX_LEN: in_ready drops, frame_err pulses once, go to PAD/FCS per REQ-020; the source discards the remainder.
REQ-023 PAD emits 0x00 until payload + pad = MIN_LEN.
REQ-024 CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF) covers payload and pad bytes only, one byte per advance slot.
REQ-025 FCS emits ~crc over 4 slots, least significant byte first; the register is not updated during FCS.
REQ-026 IFG holds out_enable and out_valid low for IFG_SLOTS advance slots, then goes to IDLE.
REQ-027 frame_count increments on the last FCS slot.
REQ-028 Outputs are registered: a byte decided on advance cycle N appears on the cycle after N.
REQ-029 in_valid high in IFG is ignored; the frame starts from IDLE on the next advance slot.
REQ-030 The byte counter is 11 bits, saturates at MAX_LEN and clears in IDLE.

Reset
REQ-031 On rst, all outputs and counters go to 0, state to IDLE and the CRC to 0xFFFFFFFF, immediately and asynchronously.
REQ-032 Reset mid-frame truncates output at once: out_enable drops with no FCS, and frame_count is unchanged.
REQ-033 After rst deasserts, the first frame starts only on an advance slot per REQ-018.

Verification
REQ-034 MIN_LEN=0, advance tied high, payload "123456789" -> 55x7, D5, 31..39, FCS 26 39 F4 CB; frame_count=1.
REQ-035 Defaults, 10-byte payload -> 10 data + 50 pad bytes, 72 out_valid slots total, then 12 idle slots before the next preamble.
REQ-036 MAX_LEN=1500, source offers 1600 bytes -> exactly 1500 transferred, one frame_err pulse, FCS follows pad-free.
REQ-037 advance high 1 cycle in 10 (100 Mb pacing) -> each output byte held 10 cycles, CRC matches the REQ-034 reference.
REQ-038 rst asserted in PAYLOAD byte 20 -> same cycle out_enable=0, busy=0; a next frame after release completes correctly.
REQ-039 in_valid gap of 3 slots mid-payload -> frame ends at the gap, pad/FCS follow, remaining bytes start a new frame after IFG.

Source files
------------

// File: rtl/eth_frame_wrapper.sv
// Wraps a byte stream into Ethernet frames (preamble, SFD, payload, pad, FCS, IFG), one byte per advance slot.
// Outputs are registered one cycle after the deciding advance slot; in_ready is high only while payload is accepted.
module eth_frame_wrapper #(
  parameter int MIN_LEN   = 60,
  parameter int MAX_LEN   = 1500,
  parameter int IFG_SLOTS = 12
) (
  input  logic        clk125MHz,
  input  logic        rst,
  input  logic        advance,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_enable,
  output logic        busy,
  output logic        frame_err,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, IFG
  } state_t;

  // The IDLE slot that precedes every preamble is the last gap slot.
  localparam int IFG_STATE_SLOTS = IFG_SLOTS - 1;

  state_t      state, state_nx;
  logic [10:0] byte_cnt, byte_cnt_nx;
  logic [7:0]  slot_cnt, slot_cnt_nx;
  logic [31:0] crc, crc_nx;
  logic [7:0]  data_nx;
  logic        valid_nx;
  logic        enable_nx;
  logic        err_nx;
  logic        frame_done;
  logic        at_max;
  logic        pad_needed;
  logic        pad_last;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign at_max     = int'(byte_cnt) >= MAX_LEN;
  assign pad_needed = int'(byte_cnt) < MIN_LEN;
  assign pad_last   = (int'(byte_cnt) + 1 >= MIN_LEN) || at_max;
  assign in_ready   = (state == PAYLOAD) && !at_max;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk125MHz or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (advance) begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (in_valid) state_nx = PREAMBLE;
      PREAMBLE: if (slot_cnt == 8'd6) state_nx = SFD;
      SFD:      state_nx = PAYLOAD;
      PAYLOAD:  if (!in_valid || at_max) state_nx = pad_needed ? PAD : FCS;
      PAD:      if (pad_last) state_nx = FCS;
      FCS:      if (slot_cnt == 8'd3) state_nx = (IFG_STATE_SLOTS > 0) ? IFG : IDLE;
      IFG:      if (int'(slot_cnt) >= IFG_STATE_SLOTS - 1) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    data_nx     = 8'h00;
    valid_nx    = 1'b0;
    enable_nx   = 1'b1;
    err_nx      = 1'b0;
    frame_done  = 1'b0;
    crc_nx      = crc;
    byte_cnt_nx = byte_cnt;
    slot_cnt_nx = 8'd0;
    case (state)
      IDLE: begin
        enable_nx   = 1'b0;
        crc_nx      = 32'hFFFFFFFF;
        byte_cnt_nx = 11'd0;
      end
      PREAMBLE: begin
        data_nx  = 8'h55;
        valid_nx = 1'b1;
        if (slot_cnt != 8'd6) slot_cnt_nx = slot_cnt + 8'd1;
      end
      SFD: begin
        data_nx  = 8'hD5;
        valid_nx = 1'b1;
      end
      PAYLOAD: begin
        if (in_valid && !at_max) begin
          data_nx     = in_data;
          valid_nx    = 1'b1;
          crc_nx      = crc_step(crc, in_data);
          byte_cnt_nx = byte_cnt + 11'd1;
        end else begin
          // Source still offering data at the length limit means truncation.
          err_nx = in_valid;
        end
      end
      PAD: begin
        valid_nx = 1'b1;
        crc_nx   = crc_step(crc, 8'h00);
        if (!at_max) byte_cnt_nx = byte_cnt + 11'd1;
      end
      FCS: begin
        data_nx  = 8'(~crc >> {slot_cnt[1:0], 3'b000});
        valid_nx = 1'b1;
        if (slot_cnt == 8'd3) frame_done = 1'b1;
        else slot_cnt_nx = slot_cnt + 8'd1;
      end
      IFG: begin
        enable_nx   = 1'b0;
        slot_cnt_nx = slot_cnt + 8'd1;
      end
      default: enable_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk125MHz or posedge rst) begin
    if (rst) begin
      out_data    <= 8'h00;
      out_valid   <= 1'b0;
      out_enable  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= 16'h0000;
      crc         <= 32'hFFFFFFFF;
      byte_cnt    <= 11'd0;
      slot_cnt    <= 8'd0;
    end else begin
      frame_err <= advance & err_nx;
      if (advance) begin
        out_data   <= data_nx;
        out_valid  <= valid_nx;
        out_enable <= enable_nx;
        crc        <= crc_nx;
        byte_cnt   <= byte_cnt_nx;
        slot_cnt   <= slot_cnt_nx;
        if (frame_done) frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule
